// File: rtl/seq_access_pkg.sv
// Shared definitions for the access-code checker: state encoding and a width helper.
package seq_access_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_GRANT   = 3'd2,
    S_DENY    = 3'd3,
    S_LOCK    = 3'd4
  } state_t;

  // Bits needed to hold values 0..n, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/access_timer.sv
// Loadable down-counter that stops at zero and flags it.
module access_timer
  import seq_access_pkg::*;
#(
  parameter int LOAD = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_zero
);

  localparam int W = cnt_w(LOAD);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= W'(LOAD);
    else if (i_en && (r_cnt != '0))
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/seq_access_ctrl.sv
// Access-code checker: collects CODE_LEN symbols, grants or denies, and locks out
// after MAX_TRIES consecutive failures.
module seq_access_ctrl
  import seq_access_pkg::*;
#(
  parameter int SYM_W       = 1,
  parameter int CODE_LEN    = 6,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT     = 255,
  parameter int LOCK_CYCLES = 1023
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [CODE_LEN*SYM_W-1:0]    Code,
  input  logic [SYM_W-1:0]             Sym,
  input  logic                         V,
  input  logic                         Clr,
  output logic                         Allow,
  output logic                         Deny,
  output logic                         Locked,
  output logic                         Busy,
  output logic [cnt_w(CODE_LEN)-1:0]   Pos,
  output logic [cnt_w(MAX_TRIES)-1:0]  Tries
);

  localparam int POS_W = cnt_w(CODE_LEN);
  localparam int TRY_W = cnt_w(MAX_TRIES);

  state_t           r_state;
  logic             r_flag;
  logic [POS_W-1:0] r_pos;
  logic [TRY_W-1:0] r_tries;
  logic             r_allow, r_deny, r_locked, r_busy;

  logic [SYM_W-1:0] w_ref;
  logic             w_mism, w_flag_n, w_last;
  logic [TRY_W-1:0] w_tries_inc;
  logic             w_to_load, w_to_en, w_to_zero;
  logic             w_lk_load, w_lk_en, w_lk_zero;

  // Symbol 0 sits in the MSB slice of Code; r_pos is 0 whenever the FSM is idle.
  always_comb begin
    w_ref = '0;
    for (int i = 0; i < CODE_LEN; i++)
      if (r_pos == POS_W'(i))
        w_ref = Code[(CODE_LEN-1-i)*SYM_W +: SYM_W];
  end

  assign w_mism      = (Sym != w_ref);
  assign w_flag_n    = r_flag | w_mism;
  assign w_last      = (r_pos == POS_W'(CODE_LEN - 1));
  assign w_tries_inc = (r_tries == TRY_W'(MAX_TRIES)) ? r_tries : r_tries + 1'b1;

  assign w_to_load = V && ((r_state == S_IDLE) || ((r_state == S_COLLECT) && !Clr));
  assign w_to_en   = (r_state == S_COLLECT) && !V && !Clr;
  assign w_lk_load = (r_state == S_DENY);
  assign w_lk_en   = (r_state == S_LOCK);

  // Loaded with N-1 so the zero flag is seen on the Nth counting edge.
  access_timer #(.LOAD(TIMEOUT - 1)) u_timeout (
    .i_clk(Clk), .i_rst(Rst), .i_load(w_to_load), .i_en(w_to_en), .o_zero(w_to_zero)
  );

  access_timer #(.LOAD(LOCK_CYCLES - 1)) u_lock (
    .i_clk(Clk), .i_rst(Rst), .i_load(w_lk_load), .i_en(w_lk_en), .o_zero(w_lk_zero)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= S_IDLE;
      r_flag   <= 1'b0;
      r_pos    <= '0;
      r_tries  <= '0;
      r_allow  <= 1'b0;
      r_deny   <= 1'b0;
      r_locked <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_deny <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (V) begin
            r_flag  <= w_mism;
            r_pos   <= POS_W'(1);
            r_busy  <= 1'b1;
            r_state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (Clr) begin
            r_state <= S_IDLE;
            r_pos   <= '0;
            r_flag  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (V) begin
            r_flag <= w_flag_n;
            r_pos  <= r_pos + 1'b1;
            if (w_last) begin
              r_busy <= 1'b0;
              if (w_flag_n) begin
                r_state <= S_DENY;
                r_deny  <= 1'b1;
                r_tries <= w_tries_inc;
              end else begin
                r_state <= S_GRANT;
                r_allow <= 1'b1;
                r_tries <= '0;
              end
            end
          end else if (w_to_zero) begin
            r_state <= S_DENY;
            r_deny  <= 1'b1;
            r_busy  <= 1'b0;
            r_tries <= w_tries_inc;
          end
        end
        S_GRANT: begin
          if (Clr) begin
            r_state <= S_IDLE;
            r_allow <= 1'b0;
            r_pos   <= '0;
            r_flag  <= 1'b0;
          end
        end
        S_DENY: begin
          r_pos  <= '0;
          r_flag <= 1'b0;
          if (r_tries == TRY_W'(MAX_TRIES)) begin
            r_state  <= S_LOCK;
            r_locked <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOCK: begin
          if (w_lk_zero) begin
            r_state  <= S_IDLE;
            r_locked <= 1'b0;
            r_tries  <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Allow  = r_allow;
  assign Deny   = r_deny;
  assign Locked = r_locked;
  assign Busy   = r_busy;
  assign Pos    = r_pos;
  assign Tries  = r_tries;

endmodule

// File: doc/seq_access_ctrl.md
Name: seq_access_ctrl

Overview:
Parametrised access-code checker for the timed sequence-matching game.
- Collects CODE_LEN symbols of SYM_W bits, each qualified by V, and compares them against a programmable reference code Code.
- Grants or denies access once the full sequence is in. Counts failed attempts and locks out after MAX_TRIES failures.
- Aborts an entry that stalls longer than TIMEOUT cycles between symbols.
- Sits between the player input debouncer and the game-control FSM.

Parameters:
SYM_W, 1, width of one entered symbol
CODE_LEN, 6, symbols per code entry (>=2)
MAX_TRIES, 3, consecutive failed entries before lockout (>=1)
TIMEOUT, 255, max idle cycles between symbols inside an entry (>=1)
LOCK_CYCLES, 1023, lockout duration in cycles (>=1)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, asynchronous, active-high
Code  in  CODE_LEN*SYM_W  reference code; symbol 0 = MSB slice; sampled per symbol at accept time
Sym  in  SYM_W  entered symbol
V  in  1  symbol valid; one symbol is accepted per cycle with V=1
Clr  in  1  acknowledge/abort; returns block to IDLE
Allow  out  1  access granted (level)
Deny  out  1  entry failed (1-cycle pulse)
Locked  out  1  lockout active
Busy  out  1  entry in progress (state COLLECT)
Pos  out  $clog2(CODE_LEN+1)  symbols accepted in current entry
Tries  out  $clog2(MAX_TRIES+1)  consecutive failed entries

Behaviour:
- Reset values: state IDLE; Allow, Deny, Locked, Busy = 0; Pos = 0; Tries = 0; mismatch flag = 0; timers cleared. All outputs are registered.
- States: IDLE, COLLECT, GRANT, DENY, LOCK.
- IDLE:
  - V=1 accepts symbol 0; mismatch flag = (Sym != Code slice 0); Pos=1; go to COLLECT.
  - If CODE_LEN symbols would complete in the same step, the CODE_LEN rule below applies.
- COLLECT, V=1:
  - Accept the symbol; flag |= (Sym != slice Pos); Pos++; reload the timeout counter.
  - When the accepted symbol is number CODE_LEN: if the final flag is 0, go to GRANT; otherwise go to DENY.
  - There is no early exit on mismatch: every entry consumes exactly CODE_LEN symbols.
- COLLECT, V=0: the timeout counter decrements. At TIMEOUT consecutive idle cycles, go to DENY (counts as a failure).
- Latency: Allow=1, or Deny=1, in the first cycle after the clock edge that accepts the final symbol. V gaps are allowed anywhere in an entry.
- GRANT:
  - Allow held at 1; Tries cleared to 0; V ignored.
  - Clr=1 -> IDLE, with Allow=0 from the next cycle.
- DENY (exactly one cycle):
  - Deny=1; Tries++.
  - If the new Tries == MAX_TRIES, go to LOCK; else go to IDLE with Pos=0 and flag=0.
- LOCK:
  - Locked=1; V and Clr are ignored; the lock counter runs LOCK_CYCLES cycles.
  - Then go to IDLE with Tries=0 and Locked=0.
- Clr during COLLECT: abort to IDLE, with Pos=0 and flag=0. Tries is unchanged; the abort does not count as a failure.
- Clr in IDLE: no effect. Clr and final V in the same cycle: Clr wins (abort).
- Code changing mid-entry: each symbol compares against the slice present at its accept edge.
- Busy = 1 only in COLLECT. Pos reads CODE_LEN for the GRANT/DENY cycle and resets to 0 on return to IDLE.
- Tries saturates at MAX_TRIES.
- Rst asserted at any time, including mid-entry or during LOCK: immediate return to reset values, with no wait for a clock edge.

Decomposition:
- Shared package seq_access_pkg: state encoding localparams (IDLE=0, COLLECT=1, GRANT=2, DENY=3, LOCK=4, 3-bit) and a width helper function for the Pos/Tries/counter widths.
- One sub-module, access_timer: a loadable down-counter with a zero flag. Instantiate it twice, once for the inter-symbol timeout (load TIMEOUT) and once for the lockout (load LOCK_CYCLES).

Test Plan:
- Defaults, Code=6'b111111, six V pulses with Sym=1 and random 0-3 cycle gaps -> Allow=1 in the cycle after the 6th accept, Tries=0, Pos=6. Clr=1 -> Allow=0 next cycle, IDLE.
- SYM_W=4, CODE_LEN=4, Code=16'hA5C3, entry A,5,0,3 -> all 4 symbols consumed, Deny pulses for exactly 1 cycle, Tries=1, Allow stays 0.
- Three consecutive wrong entries -> third Deny, then Locked=1 for 1023 cycles. V pulses during lockout are ignored (Pos stays 0). Afterwards IDLE with Tries=0; a correct entry then yields Allow.
- Three symbols entered, then V held low for 255 cycles -> Deny pulse, Tries=1, Pos=0. A correct full entry afterwards -> Allow, Tries=0.
- Clr pulsed after 3 symbols -> Busy=0, Pos=0, Tries unchanged; Clr coincident with the 6th V -> abort, no Allow and no Deny.
- Rst asserted asynchronously between edges mid-COLLECT and mid-LOCK -> all outputs 0 immediately. After release, a correct entry yields Allow.
